// File: rtl/pe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pe (with register-file helper pe_rf)                         |
// | Description : Processing element; loads filter/ifmap taps, runs a signed   |
// |               MAC over them, then adds the upstream partial sum.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module pe_rf #(
    parameter int BITWIDTH      = 16,
    parameter int RF_ADDR_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       wr_en,
    input  logic [RF_ADDR_WIDTH-1:0]   wr_addr,
    input  logic signed [BITWIDTH-1:0] wr_data,
    input  logic [RF_ADDR_WIDTH-1:0]   rd_addr,
    output logic signed [BITWIDTH-1:0] rd_data
);
    localparam int c_depth = 2 ** RF_ADDR_WIDTH;

    logic signed [BITWIDTH-1:0] memory [c_depth];

    always_ff @(posedge clk) begin
        if (rstb) begin
            for (int k = 0; k < c_depth; k++) begin
                memory[k] <= '0;
            end
        end else if (wr_en) begin
            memory[wr_addr] <= wr_data;
        end
    end

    assign rd_data = memory[rd_addr];
endmodule

module pe #(
    parameter int BITWIDTH         = 16,
    parameter int RF_ADDR_WIDTH    = 3,
    parameter int KERNEL_SIZE      = 3,
    parameter int WHEN_TO_ACC_PSUM = 5
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       ifmap_enable,
    input  logic                       filter_enable,
    input  logic signed [BITWIDTH-1:0] ifmap,
    input  logic signed [BITWIDTH-1:0] filter,
    input  logic signed [BITWIDTH-1:0] input_psum,
    output logic                       ready,
    output logic signed [BITWIDTH-1:0] output_psum
);
    localparam int                     c_cnt_w     = RF_ADDR_WIDTH + 3;
    localparam logic [RF_ADDR_WIDTH:0] c_ptr_full  = (RF_ADDR_WIDTH + 1)'(KERNEL_SIZE);
    localparam logic [c_cnt_w-1:0]     c_mac_last  = c_cnt_w'(KERNEL_SIZE - 1);
    localparam logic [c_cnt_w-1:0]     c_hold_last = c_cnt_w'(WHEN_TO_ACC_PSUM - 1);
    localparam bit                     c_need_hold = (WHEN_TO_ACC_PSUM > KERNEL_SIZE);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        MAC  = 2'd1,
        HOLD = 2'd2,
        ACC  = 2'd3
    } pe_state_t;

    pe_state_t                  pe_state;
    logic [c_cnt_w-1:0]         count;
    logic [RF_ADDR_WIDTH:0]     r_filter_ptr;
    logic [RF_ADDR_WIDTH:0]     r_ifmap_ptr;
    logic signed [BITWIDTH-1:0] r_accumulator;

    logic                       w_filter_full;
    logic                       w_ifmap_full;
    logic                       w_filter_wr;
    logic                       w_ifmap_wr;
    logic                       w_psum_wr;
    logic [RF_ADDR_WIDTH-1:0]   w_select;
    logic signed [BITWIDTH-1:0] w_filter_rd;
    logic signed [BITWIDTH-1:0] w_ifmap_rd;
    logic signed [BITWIDTH-1:0] w_psum_rd;
    logic signed [BITWIDTH-1:0] w_product;
    logic signed [BITWIDTH-1:0] w_sum;

    assign w_filter_full = (r_filter_ptr == c_ptr_full);
    assign w_ifmap_full  = (r_ifmap_ptr == c_ptr_full);
    assign w_filter_wr   = (pe_state == LOAD) && filter_enable && !w_filter_full;
    assign w_ifmap_wr    = (pe_state == LOAD) && ifmap_enable && !w_ifmap_full;
    assign w_psum_wr     = (pe_state == MAC);
    assign w_select      = count[RF_ADDR_WIDTH-1:0];

    // Same-width multiply/add keeps exactly the low BITWIDTH bits (wrapping).
    assign w_product = w_filter_rd * w_ifmap_rd;
    assign w_sum     = r_accumulator + w_product;

    pe_rf #(.BITWIDTH(BITWIDTH), .RF_ADDR_WIDTH(RF_ADDR_WIDTH)) filter_fifo (
        .clk     (clk),
        .rstb    (rstb),
        .wr_en   (w_filter_wr),
        .wr_addr (r_filter_ptr[RF_ADDR_WIDTH-1:0]),
        .wr_data (filter),
        .rd_addr (w_select),
        .rd_data (w_filter_rd)
    );

    pe_rf #(.BITWIDTH(BITWIDTH), .RF_ADDR_WIDTH(RF_ADDR_WIDTH)) ifmap_fifo (
        .clk     (clk),
        .rstb    (rstb),
        .wr_en   (w_ifmap_wr),
        .wr_addr (r_ifmap_ptr[RF_ADDR_WIDTH-1:0]),
        .wr_data (ifmap),
        .rd_addr (w_select),
        .rd_data (w_ifmap_rd)
    );

    // Entry 0 mirrors the running sum, so it equals the accumulator once MAC ends.
    pe_rf #(.BITWIDTH(BITWIDTH), .RF_ADDR_WIDTH(RF_ADDR_WIDTH)) psum_fifo (
        .clk     (clk),
        .rstb    (rstb),
        .wr_en   (w_psum_wr),
        .wr_addr ('0),
        .wr_data (w_sum),
        .rd_addr ('0),
        .rd_data (w_psum_rd)
    );

    always_ff @(posedge clk) begin
        if (rstb) begin
            pe_state      <= LOAD;
            count         <= '0;
            r_filter_ptr  <= '0;
            r_ifmap_ptr   <= '0;
            r_accumulator <= '0;
            output_psum   <= '0;
            ready         <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (pe_state)
                LOAD: begin
                    if (w_filter_wr) r_filter_ptr <= r_filter_ptr + 1'b1;
                    if (w_ifmap_wr)  r_ifmap_ptr  <= r_ifmap_ptr + 1'b1;
                    if (w_filter_full && w_ifmap_full) begin
                        pe_state <= MAC;
                        count    <= '0;
                    end
                end
                MAC: begin
                    r_accumulator <= w_sum;
                    count         <= count + 1'b1;
                    if (count == c_mac_last) begin
                        pe_state <= c_need_hold ? HOLD : ACC;
                    end
                end
                HOLD: begin
                    count <= count + 1'b1;
                    if (count == c_hold_last) begin
                        pe_state <= ACC;
                    end
                end
                ACC: begin
                    output_psum   <= w_psum_rd + input_psum;
                    ready         <= 1'b1;
                    pe_state      <= LOAD;
                    count         <= '0;
                    r_filter_ptr  <= '0;
                    r_ifmap_ptr   <= '0;
                    r_accumulator <= '0;
                end
                default: pe_state <= LOAD;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pe                                                        |
// | Description : Directed self-checking bench for the pe MAC element.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pe;
    logic               clk = 1'b0;
    logic               rstb;
    logic               ifmap_enable;
    logic               filter_enable;
    logic signed [15:0] ifmap;
    logic signed [15:0] filter;
    logic signed [15:0] input_psum;
    logic               ready;
    logic signed [15:0] output_psum;

    int checks   = 0;
    int failures = 0;

    pe #(.BITWIDTH(16), .RF_ADDR_WIDTH(3), .KERNEL_SIZE(3), .WHEN_TO_ACC_PSUM(5)) dut (
        .clk           (clk),
        .rstb          (rstb),
        .ifmap_enable  (ifmap_enable),
        .filter_enable (filter_enable),
        .ifmap         (ifmap),
        .filter        (filter),
        .input_psum    (input_psum),
        .ready         (ready),
        .output_psum   (output_psum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstb          = 1'b1;
        filter_enable = 1'b0;
        ifmap_enable  = 1'b0;
        tick();
        tick();
        rstb = 1'b0;
    endtask

    task automatic load3(input logic signed [15:0] f0, f1, f2, i0, i1, i2);
        logic signed [15:0] fs [3];
        logic signed [15:0] is [3];
        fs = '{f0, f1, f2};
        is = '{i0, i1, i2};
        for (int k = 0; k < 3; k++) begin
            filter_enable = 1'b1; filter = fs[k];
            tick();
            filter_enable = 1'b0;
            ifmap_enable  = 1'b1; ifmap = is[k];
            tick();
            ifmap_enable  = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("fmem%0d", k), dut.filter_fifo.memory[k], fs[k]);
            chk($sformatf("imem%0d", k), dut.ifmap_fifo.memory[k], is[k]);
        end
    endtask

    // Loads one kernel, runs it, and checks running sums, latency and the result.
    task automatic run_vec(input string tag, input logic signed [15:0] f0, f1, f2,
                           input logic signed [15:0] i0, i1, i2,
                           input logic signed [15:0] psum, junk,
                           input int exp, input bit poke);
        logic signed [15:0] fs [3];
        logic signed [15:0] is [3];
        logic signed [15:0] part;
        int edges;
        fs = '{f0, f1, f2};
        is = '{i0, i1, i2};
        part = '0;
        input_psum = junk;
        load3(f0, f1, f2, i0, i1, i2);
        if (poke) begin
            filter_enable = 1'b1; filter = 16'sd9;
        end
        tick();
        chk({tag, "_state_mac"}, dut.pe_state, 1);
        edges = 0;
        while (!ready && edges < 20) begin
            input_psum = (edges == 5) ? psum : junk;
            if (poke) begin
                filter_enable = (edges < 3); filter = 16'sd9;
                ifmap_enable  = (edges < 3); ifmap  = 16'sd9;
            end
            tick();
            edges++;
            if (edges <= 3) begin
                part = part + fs[edges-1] * is[edges-1];
                chk($sformatf("%s_part%0d", tag, edges), dut.psum_fifo.memory[0], part);
            end
        end
        filter_enable = 1'b0;
        ifmap_enable  = 1'b0;
        chk({tag, "_latency"}, edges, 6);
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_out"}, output_psum, exp);
        input_psum = junk;
        tick();
        chk({tag, "_ready_pulse"}, ready, 0);
        chk({tag, "_out_hold"}, output_psum, exp);
        chk({tag, "_state_load"}, dut.pe_state, 0);
    endtask

    initial begin
        filter = '0; ifmap = '0; input_psum = '0;
        do_reset();
        chk("rst_ready", ready, 0);
        chk("rst_out", output_psum, 0);
        chk("rst_state", dut.pe_state, 0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rst_fmem%0d", k), dut.filter_fifo.memory[k], 0);
            chk($sformatf("rst_imem%0d", k), dut.ifmap_fifo.memory[k], 0);
            chk($sformatf("rst_pmem%0d", k), dut.psum_fifo.memory[k], 0);
        end

        run_vec("basic", 1, 2, 3, 1, 2, 3, 16'sd0, 16'sd0, 14, 1'b0);
        run_vec("psum", 1, 2, 3, 1, 2, 3, 16'sd10, 16'sh0777, 24, 1'b0);
        run_vec("neg", -2, 3, 4, 5, -1, 2, 16'sd0, -16'sd3, -5, 1'b0);
        run_vec("wrap", 256, 256, 0, 256, 1, 0, 16'sd0, 16'sd99, 256, 1'b0);

        do_reset();
        run_vec("ignore", 1, 2, 3, 1, 2, 3, 16'sd0, 16'sd0, 14, 1'b1);
        chk("ignore_fmem3", dut.filter_fifo.memory[3], 0);
        chk("ignore_imem3", dut.ifmap_fifo.memory[3], 0);

        // Abort a sequence at MAC count 1; output_psum still holds 14 going in.
        input_psum = 16'sd0;
        load3(1, 2, 3, 1, 2, 3);
        tick();
        tick();
        chk("mid_state", dut.pe_state, 1);
        chk("mid_count", dut.count, 1);
        rstb = 1'b1;
        tick();
        rstb = 1'b0;
        chk("mid_rst_state", dut.pe_state, 0);
        chk("mid_rst_count", dut.count, 0);
        chk("mid_rst_out", output_psum, 0);
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_fmem0", dut.filter_fifo.memory[0], 0);
        chk("mid_rst_imem2", dut.ifmap_fifo.memory[2], 0);
        chk("mid_rst_pmem0", dut.psum_fifo.memory[0], 0);
        run_vec("after_rst", 1, 2, 3, 1, 2, 3, 16'sd0, 16'sd0, 14, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=%0d expected=%0d", 0, 1);
        $fatal(1, "tb_pe timeout");
    end
endmodule
`default_nettype wire

// File: doc/pe.md
PE -- requirements
Module: pe

Interface
REQ-001 SHALL have parameter BITWIDTH, default 16, data width of filter, ifmap, psum and all arithmetic.
REQ-002 SHALL have parameter RF_ADDR_WIDTH, default 3, address width of each register file; depth is 2^RF_ADDR_WIDTH (8).
REQ-003 SHALL have parameter KERNEL_SIZE, default 3, number of filter/ifmap pairs per MAC sequence; legal range 1..2^RF_ADDR_WIDTH.
REQ-004 SHALL have parameter WHEN_TO_ACC_PSUM, default 5, count value at which input_psum is added; legal range >= KERNEL_SIZE.
REQ-005 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port: rstb  input  1  reset; synchronous, active-high (1 = reset).
REQ-007 SHALL have port: ifmap_enable  input  1  write ifmap into ifmap RF this cycle.
REQ-008 SHALL have port: filter_enable  input  1  write filter into filter RF this cycle.
REQ-009 SHALL have port: ifmap  input  BITWIDTH signed  ifmap write data.
REQ-010 SHALL have port: filter  input  BITWIDTH signed  filter write data.
REQ-011 SHALL have port: input_psum  input  BITWIDTH signed  upstream partial sum from the PE below.
REQ-012 SHALL have port: ready  output  1  one-cycle pulse, output_psum newly valid.
REQ-013 SHALL have port: output_psum  output  BITWIDTH signed  registered result.

Function
REQ-014 SHALL contain three RFs (filter_fifo, ifmap_fifo, psum_fifo), each 2^RF_ADDR_WIDTH x BITWIDTH, array named memory, with write pointers.
REQ-015 SHALL implement states LOAD=0, MAC=1, HOLD=2, ACC=3 (pe_state) and a RF_ADDR_WIDTH+3-bit counter count.
REQ-016 LOAD: filter_enable=1 writes filter to filter_fifo.memory[filter wr ptr], ptr+1; ifmap_enable likewise into ifmap_fifo; both may write in the same cycle.
REQ-017 LOAD: writes when that RF already holds KERNEL_SIZE entries SHALL be ignored (full); no wrap-around.
REQ-018 LOAD -> MAC on the edge following the cycle in which both RFs hold KERNEL_SIZE entries; count=0 on MAC entry.
REQ-019 ifmap_enable/filter_enable outside LOAD SHALL be ignored.
REQ-020 MAC cycle with count=c: filter_select=ifmap_select=c; product = filter_fifo.memory[c] * ifmap_fifo.memory[c]; accumulator <= accumulator + product; running sum also written to psum_fifo.memory[0] (psum_select=0); count+1.
REQ-021 Product and sum SHALL be signed two's complement, truncated to low BITWIDTH bits (wraps, no saturation).
REQ-022 MAC -> HOLD after count=KERNEL_SIZE-1 if WHEN_TO_ACC_PSUM > KERNEL_SIZE, else -> ACC; HOLD increments count, no arithmetic, -> ACC when count reaches WHEN_TO_ACC_PSUM.
REQ-023 ACC (count=WHEN_TO_ACC_PSUM, acc_input_psum=1): output_psum <= accumulator + input_psum (input_psum sampled this cycle only), ready <= 1.
REQ-024 After ACC the PE SHALL return to LOAD with write pointers, count and accumulator cleared (acc_reset=1 for that edge); RF contents kept.
REQ-025 ready SHALL be high exactly one cycle (cycle after ACC); output_psum holds until next ACC or reset.
REQ-026 Latency: ready rises WHEN_TO_ACC_PSUM+1 edges after the first MAC edge.

Reset
REQ-027 rstb=1 at a rising edge SHALL, in any state including mid-MAC: state LOAD, count 0, pointers 0, accumulator 0, all RF memory 0, output_psum 0, ready 0; any in-progress sum discarded.

Verification
REQ-028 Reset then idle -> ready=0, output_psum=0, all RF entries 0, pe_state=0.
REQ-029 Alternate loads filter 1,ifmap 1,filter 2,ifmap 2,filter 3,ifmap 3, input_psum=0 -> memory[0..2]={1,2,3} both RFs; MAC accumulator 1,5,14; output_psum=14, ready one-cycle pulse 6 edges after first MAC edge.
REQ-030 Same loads, input_psum=10 during ACC (other values elsewhere) -> output_psum=24.
REQ-031 Filters -2,3,4 and ifmaps 5,-1,2 -> output_psum=-5; filters 256,256,0 and ifmaps 256,1,0 (BITWIDTH 16) -> 65536+256 wraps to 256.
REQ-032 Extra filter_enable with value 9 after 3 loaded -> ignored, filter_fifo.memory[3]=0, result unchanged; enables during MAC ignored.
REQ-033 rstb=1 during MAC count=1 -> next cycle all state 0; subsequent full load of 1,2,3 sequence yields 14.
